multiword_alu_sequencer: RTL
============================

Name: multiword_alu_sequencer

Overview:
- Multi-precision front end for the 16-bit ArithmeticUnit.
- Accepts one 1–4 word (16–64-bit) operation per request and issues it to the unit one 16-bit slice per cycle, least significant word first.
- Chains carry_out back into carry_in between slices, and collects the result words and flags into a single response.
- Drives the unit's inputs and consumes its outputs; the unit stays a sibling instance in the parent.

Parameters:
- WORD_W, 16: slice width; must equal the ArithmeticUnit width.
- MAX_WORDS, 4: maximum words per operation.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_sel  in  4  ArithmeticUnit op select
- req_carry_in  in  1  carry into word 0
- req_words  in  3  word count, 1..MAX_WORDS
- req_a  in  64  operand A, word i at [16i+15:16i]
- req_b  in  64  operand B
- au_in_a  out  16  slice of A to unit
- au_in_b  out  16  slice of B to unit
- au_sel  out  4  op select to unit
- au_carry_in  out  1  carry to unit
- au_out  in  16  unit result
- au_carry_out  in  1  unit carry
- au_compare  in  1  unit slice equality
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_result  out  64  assembled result; unused upper words are 0
- rsp_carry  out  1  carry_out of final word
- rsp_equal  out  1  AND of au_compare over all used words
- rsp_zero  out  1  all used result words zero

Behaviour:
- Clock and reset: one clock domain, clk. Synchronous active-high reset rst.
- Reset values:
  - state IDLE.
  - rsp_valid 0, rsp_result 0, rsp_carry 0, rsp_equal 0, rsp_zero 0.
  - Internal word index 0.
  - req_ready is combinational (state==IDLE && !rst): 0 during the reset cycle, 1 the cycle after.
- Word-count clamp at accept: req_words 0 is treated as 1; values >MAX_WORDS are treated as MAX_WORDS.
- FSM states IDLE, RUN, DONE:
  - IDLE: req_ready=1. On req_valid:
    - latch sel, A, B and the clamped word count;
    - carry_reg<=req_carry_in, idx<=0, eq_acc<=1, zero_acc<=1, rsp_result<=0;
    - go to RUN.
  - RUN: au_in_a/au_in_b = latched slice idx, au_sel = latched sel, au_carry_in = carry_reg. Same cycle (the unit is combinational), capture:
    - au_out into result word idx;
    - eq_acc&=au_compare, zero_acc&=(au_out==0);
    - carry_reg<= chained(sel) ? au_carry_out : latched req_carry_in.
    - If idx==words-1: latch rsp_carry<=au_carry_out, go to DONE. Else idx++.
  - DONE: rsp_valid=1; rsp_* held stable. On rsp_ready, go to IDLE and drop rsp_valid next cycle.
- Unit inputs outside RUN: au_in_a, au_in_b, au_sel, au_carry_in driven 0.
- Chained ops: sel ∈ {0101,1000,1001,1010,1100,1101,1110}. Every other sel processes each slice independently with the original carry_in. Unused by the unit; harmless.
- Latency: request accepted in cycle t → rsp_valid first high at t+N+1 for N words.
- Throughput: one op per N+2 cycles minimum. No overlap: req_ready=0 in RUN and DONE.
- rsp_ready held low: DONE persists indefinitely, outputs stable.
- rsp_ready high on the first DONE cycle: single-cycle rsp_valid.
- Reset mid-RUN or mid-DONE: operation abandoned, no response, all reset values restored.
- Requests presented while rst=1 are ignored.

Decomposition:
- Package alu_pkg:
  - WORD_W, MAX_WORDS;
  - 4-bit sel localparams (SEL_ADD=1001, SEL_ONES=0011, etc.);
  - state enum {IDLE,RUN,DONE};
  - function is_chained(sel).
- No sub-module needed; slice select is an indexed part-select inside the block.

Test Plan:
1. sel=1001, a=0x0001, b=0x0002, cin=0, words=1 → result 0x0003, carry 0, equal 0, zero 0; rsp_valid exactly 2 cycles after accept.
2. sel=1001, a=0x0000_FFFF, b=0x0000_0001, words=2 → word-1 cycle shows au_carry_in=1; result 0x0000_0001_0000, carry 0.
3. sel=1001, a=0xFFFF_FFFF_FFFF_FFFF, b=1, words=4 → result 0, carry 1, zero 1, rsp_valid at t+5.
4. sel=0011 (non-chained), words=3, cin=1 → au_carry_in=1 on all three slices; result 0x0000_FFFF_FFFF_FFFF; a=b → equal 1.
5. words=0 → behaves as 1 word. Words=7 → behaves as 4 words. Then rsp_ready held low 5 cycles → rsp_* stable, req_ready 0; release → IDLE next cycle.
6. rst asserted during RUN after word 0 → rsp_valid never asserted, req_ready 1 on the cycle after rst falls, next request completes normally.

Source files
------------

// File: rtl/multiword_alu_sequencer_pkg.sv
// Shared constants, op-select codes, FSM states and helpers for the
// multi-precision sequencer in front of the 16-bit ArithmeticUnit.
package alu_pkg;

   localparam int unsigned WORD_W    = 16;
   localparam int unsigned MAX_WORDS = 4;
   localparam int unsigned DATA_W    = WORD_W * MAX_WORDS;

   localparam logic [2:0] MAX_WORDS_W = 3'(MAX_WORDS);

   // ArithmeticUnit op selects
   localparam logic [3:0] SEL_ONES = 4'b0011;
   localparam logic [3:0] SEL_INC  = 4'b0101;
   localparam logic [3:0] SEL_DEC  = 4'b1000;
   localparam logic [3:0] SEL_ADD  = 4'b1001;
   localparam logic [3:0] SEL_SUB  = 4'b1010;
   localparam logic [3:0] SEL_SHL  = 4'b1100;
   localparam logic [3:0] SEL_ROL  = 4'b1101;
   localparam logic [3:0] SEL_ROR  = 4'b1110;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Ops whose carry_out feeds the next slice's carry_in
   function automatic logic is_chained(input logic [3:0] sel);
      case (sel)
         SEL_INC, SEL_DEC, SEL_ADD, SEL_SUB,
         SEL_SHL, SEL_ROL, SEL_ROR: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

   // Word count 0 means one word; anything above MAX_WORDS saturates
   function automatic logic [2:0] clamp_words(input logic [2:0] words);
      if (words == 3'd0)
         return 3'd1;
      else if (words > MAX_WORDS_W)
         return MAX_WORDS_W;
      else
         return words;
   endfunction

endpackage

// File: rtl/multiword_alu_sequencer_if.sv
// Request/response handshake bundle of the multi-precision sequencer.
interface multiword_alu_sequencer_if;
   import alu_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_sel;
   logic              req_carry_in;
   logic [2:0]        req_words;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_carry;
   logic              rsp_equal;
   logic              rsp_zero;

   modport master (
      output req_valid, req_sel, req_carry_in, req_words, req_a, req_b,
      input  req_ready,
      input  rsp_valid, rsp_result, rsp_carry, rsp_equal, rsp_zero,
      output rsp_ready
   );

   modport slave (
      input  req_valid, req_sel, req_carry_in, req_words, req_a, req_b,
      output req_ready,
      output rsp_valid, rsp_result, rsp_carry, rsp_equal, rsp_zero,
      input  rsp_ready
   );

endinterface

// File: rtl/multiword_alu_sequencer.sv
// Issues a 1..4 word operation to the 16-bit ArithmeticUnit one slice per
// cycle (LSW first), chaining carries, and returns one assembled response.
module multiword_alu_sequencer
   import alu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   multiword_alu_sequencer_if.slave bus,
   output logic [WORD_W-1:0]    au_in_a,
   output logic [WORD_W-1:0]    au_in_b,
   output logic [3:0]           au_sel,
   output logic                 au_carry_in,
   input  logic [WORD_W-1:0]    au_out,
   input  logic                 au_carry_out,
   input  logic                 au_compare
);

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        sel_q;
   logic              cin_q;
   logic [2:0]        words_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic              carry_reg;
   logic [1:0]        idx;
   logic              eq_acc;
   logic              zero_acc;
   logic              last_word;

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state, handshake outputs and unit drive
   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      au_in_a       = '0;
      au_in_b       = '0;
      au_sel        = '0;
      au_carry_in   = 1'b0;
      last_word     = ({1'b0, idx} == (words_q - 3'd1));
      unique case (state)
         IDLE: begin
            bus.req_ready = !rst;
            if (bus.req_valid)
               state_nxt = RUN;
         end
         RUN: begin
            au_in_a     = a_q[idx*WORD_W +: WORD_W];
            au_in_b     = b_q[idx*WORD_W +: WORD_W];
            au_sel      = sel_q;
            au_carry_in = carry_reg;
            if (last_word)
               state_nxt = DONE;
         end
         DONE: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch, per-slice capture and response accumulation
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q          <= '0;
         cin_q          <= 1'b0;
         words_q        <= 3'd1;
         a_q            <= '0;
         b_q            <= '0;
         carry_reg      <= 1'b0;
         idx            <= '0;
         eq_acc         <= 1'b0;
         zero_acc       <= 1'b0;
         bus.rsp_result <= '0;
         bus.rsp_carry  <= 1'b0;
         bus.rsp_equal  <= 1'b0;
         bus.rsp_zero   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  sel_q          <= bus.req_sel;
                  cin_q          <= bus.req_carry_in;
                  words_q        <= clamp_words(bus.req_words);
                  a_q            <= bus.req_a;
                  b_q            <= bus.req_b;
                  carry_reg      <= bus.req_carry_in;
                  idx            <= '0;
                  eq_acc         <= 1'b1;
                  zero_acc       <= 1'b1;
                  bus.rsp_result <= '0;
               end
            end
            RUN: begin
               bus.rsp_result[idx*WORD_W +: WORD_W] <= au_out;
               eq_acc    <= eq_acc & au_compare;
               zero_acc  <= zero_acc & (au_out == '0);
               carry_reg <= is_chained(sel_q) ? au_carry_out : cin_q;
               // Flags are finalised here so DONE sees the last slice folded in
               if (last_word) begin
                  bus.rsp_carry <= au_carry_out;
                  bus.rsp_equal <= eq_acc & au_compare;
                  bus.rsp_zero  <= zero_acc & (au_out == '0);
               end else begin
                  idx <= idx + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
